sobel3x3_edge: RTL and testbench
================================

# sobel3x3_edge

Consumes the three row-aligned line-buffer streams produced by the 3x3 line-shift stage and emits one Sobel gradient magnitude pixel per input pixel. The block builds a 3x3 window from the three rows with replicate-border handling and runs a 3-stage arithmetic pipeline. Its output is a single AXI-Stream-like video stream with frame size and tuser/tlast framing unchanged. The stage has no backpressure: upstream tready is tied high and this block has no ready input.

## Interface
- DATA_WIDTH, 8, pixel width for inputs and output.
- s_axis_aclk  in  1  sole clock.
- srst  in  1  synchronous active-high reset.
- s_axis_line_buff_0_tvalid / _tdata  in  1 / DATA_WIDTH  newest row (row below centre).
- s_axis_line_buff_1_tvalid / _tdata / _tlast / _tuser  in  1 / DATA_WIDTH / 1 / 1  centre row; the only stream carrying framing.
- s_axis_line_buff_2_tvalid / _tdata  in  1 / DATA_WIDTH  oldest row (row above centre).
- m_axis_tvalid  out  1  output pixel valid.
- m_axis_tdata  out  DATA_WIDTH  saturated |Gx|+|Gy|.
- m_axis_tlast  out  1  last pixel of the line.
- m_axis_tuser  out  1  first pixel of the frame.

## Operation
- Column accept: a cycle with line_buff_1_tvalid=1.
- Vertical border rule:
  - Top tap = row2 data if row2_tvalid, else row1 data (first line).
  - Bottom tap = row0 data if row0_tvalid, else row1 data (flush of the last line).
  - These selected values form the new column N.
- Window registers: A (column x-1) and B (column x), 3 pixels each.
- first_col flag: set by srst and after each accepted tlast column.
- On accept with first_col=1: A<=N, B<=N, clear first_col. No emission; this replicates the left edge.
- On accept with first_col=0: emit window (A,B,N) for pixel x, then A<=B, B<=N.
- pend_last flag: set on accepting a column with tlast=1. Cleared the next cycle, which emits window (A,B,B) to replicate the right edge.
  - The pend_last emission uses the pre-update A/B.
  - It is legal in the same cycle that column 0 of the next line is accepted, because column 0 never emits. No idle cycle is required between lines.
  - A one-pixel line (column 0 carries tlast) emits (B,B,B).
- Sideband per emission:
  - tuser = row1_tuser captured at column 0 of that line, asserted only on pixel 0.
  - tlast = 1 only on the pend_last emission.
- Arithmetic on window w[r][c] (r0 = top, c0 = left):
  - Gx = (w02+2w12+w22) - (w00+2w10+w20)
  - Gy = (w20+2w21+w22) - (w00+2w01+w02)
  - Gx and Gy are signed, DATA_WIDTH+4 bits.
  - mag = |Gx|+|Gy|, DATA_WIDTH+4 bits unsigned.
  - Output = mag > 2^DATA_WIDTH-1 ? 2^DATA_WIDTH-1 : mag.
- Input tuser does not clear state. Framing is carried by the data path only.

## Timing
- Emission event at cycle t produces m_axis_* at t+3:
  - S1 registers Gx, Gy.
  - S2 registers mag.
  - S3 registers the saturated output.
- Sideband bits ride the same 3-stage valid pipeline.
- Throughput: one pixel per clock sustained. Emissions never exceed one per cycle by construction.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0.
  - Also on reset: all pipeline valids 0, pend_last=0, first_col=1.
  - A and B are don't-care.
- srst mid-line: in-flight pixels are discarded. The next accepted column is treated as column 0 of a line.
- srst has priority over a coincident accept and over a pending emission.
- Output count: exactly one output per accepted column; tlast count equals input row1 tlast count.

## Test plan
- Constant 4x4 frame, all pixels 77 -> 16 outputs, all tdata=0; tuser only on output 0; tlast on outputs 3, 7, 11, 15.
- 4x4 frame, columns 0-1 = 0 and columns 2-3 = 10, all rows -> each line outputs 0, 40, 40, 0.
- First line with row2_tvalid=0, row1 line = 0,0,0,0 and row0 line = 20,20,20,20 -> Gy=80 per pixel, so line outputs 80, 80, 80, 80.
- Back-to-back lines (column 0 accepted the cycle after tlast), width 3 -> outputs contiguous with no dropped pixel; tlast on every third output; latency from tlast accept to the tlast output = 4 cycles.
- Width-1 lines, two lines, value 200 -> one output per line, tdata=0, tlast=1 on both.
- Saturation: centre column 0 with right column 255 on all rows and left 0 -> Gx=1020, tdata=255. Then assert srst mid-line for 1 cycle -> m_axis_tvalid=0 the next cycle; the next accepted column emits nothing (treated as column 0).

Source files
------------

// File: rtl/sobel3x3_edge.sv
// -----------------------------------------------------------------------------
// sobel3x3_edge
//   Builds a 3x3 window from three row-aligned line-buffer streams and emits
//   one saturated Sobel magnitude (|Gx|+|Gy|) per accepted centre-row column.
//   Borders are replicated on all four sides. Three-stage arithmetic pipeline,
//   no backpressure, one pixel per clock sustained.
//
// Ports
//   s_axis_aclk                    clock
//   srst                           synchronous active-high reset
//   s_axis_line_buff_0_*           row below centre (tvalid, tdata)
//   s_axis_line_buff_1_*           centre row (tvalid, tdata, tlast, tuser)
//   s_axis_line_buff_2_*           row above centre (tvalid, tdata)
//   m_axis_*                       output stream (tvalid, tdata, tlast, tuser)
// -----------------------------------------------------------------------------
module sobel3x3_edge #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  s_axis_aclk,
    input  logic                  srst,
    input  logic                  s_axis_line_buff_0_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_line_buff_0_tdata,
    input  logic                  s_axis_line_buff_1_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_line_buff_1_tdata,
    input  logic                  s_axis_line_buff_1_tlast,
    input  logic                  s_axis_line_buff_1_tuser,
    input  logic                  s_axis_line_buff_2_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_line_buff_2_tdata,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);

    localparam int GW = DATA_WIDTH + 4;

    function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] p);
        return signed'({4'b0000, p});
    endfunction

    function automatic logic [GW-1:0] abs_g(input logic signed [GW-1:0] v);
        return v[GW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_pix(input logic [GW-1:0] m);
        return (|m[GW-1:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : m[DATA_WIDTH-1:0];
    endfunction

    // window columns: A = x-1, B = x
    logic [DATA_WIDTH-1:0] a_top, a_mid, a_bot;
    logic [DATA_WIDTH-1:0] b_top, b_mid, b_bot;
    logic [DATA_WIDTH-1:0] n_top, n_mid, n_bot;
    logic [DATA_WIDTH-1:0] r_top, r_mid, r_bot;

    logic first_col, pend_last, pix0_pend, line_tuser;
    logic accept, emit_norm, emit, emit_tlast, emit_tuser;

    logic signed [GW-1:0] gx_p0, gy_p0, gx_p1, gy_p1;
    logic        [GW-1:0] mag_p2;
    logic                 vld_p1, last_p1, user_p1;
    logic                 vld_p2, last_p2, user_p2;

    // ---- stage 0: column assembly and window selection ----
    always_comb begin
        accept = s_axis_line_buff_1_tvalid;
        // missing neighbour rows fall back to the centre row (top/bottom edge)
        n_top  = s_axis_line_buff_2_tvalid ? s_axis_line_buff_2_tdata : s_axis_line_buff_1_tdata;
        n_mid  = s_axis_line_buff_1_tdata;
        n_bot  = s_axis_line_buff_0_tvalid ? s_axis_line_buff_0_tdata : s_axis_line_buff_1_tdata;

        // pend_last implies first_col, so the two emission sources never collide
        emit_norm  = accept && !first_col;
        emit       = emit_norm || pend_last;
        emit_tlast = pend_last;
        emit_tuser = line_tuser && pix0_pend;

        // right-edge replication reuses B as the right column
        r_top = pend_last ? b_top : n_top;
        r_mid = pend_last ? b_mid : n_mid;
        r_bot = pend_last ? b_bot : n_bot;

        gx_p0 = (ext(r_top) + (ext(r_mid) <<< 1) + ext(r_bot))
              - (ext(a_top) + (ext(a_mid) <<< 1) + ext(a_bot));
        gy_p0 = (ext(a_bot) + (ext(b_bot) <<< 1) + ext(r_bot))
              - (ext(a_top) + (ext(b_top) <<< 1) + ext(r_top));
    end

    // ---- control: framing flags and valid/sideband pipeline ----
    always_ff @(posedge s_axis_aclk) begin
        if (srst) begin
            first_col     <= 1'b1;
            pend_last     <= 1'b0;
            pix0_pend     <= 1'b0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            last_p1       <= 1'b0;
            last_p2       <= 1'b0;
            user_p1       <= 1'b0;
            user_p2       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            pend_last <= accept && s_axis_line_buff_1_tlast;
            if (emit) begin
                pix0_pend <= 1'b0;
            end
            // a column-0 accept may coincide with the previous line's last emission;
            // the emission above used the old flags, the new line's flags win here
            if (accept) begin
                if (first_col) begin
                    pix0_pend  <= 1'b1;
                    line_tuser <= s_axis_line_buff_1_tuser;
                end
                first_col <= s_axis_line_buff_1_tlast;
            end

            // ---- stage 1 -> stage 2 ----
            vld_p1  <= emit;
            last_p1 <= emit_tlast;
            user_p1 <= emit_tuser;
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
            user_p2 <= user_p1;

            // ---- stage 3: output register ----
            m_axis_tvalid <= vld_p2;
            m_axis_tlast  <= last_p2;
            m_axis_tuser  <= user_p2;
            m_axis_tdata  <= sat_pix(mag_p2);
        end
    end

    // ---- data path: window shift and arithmetic stages ----
    always_ff @(posedge s_axis_aclk) begin
        if (accept) begin
            if (first_col) begin
                // left-edge replication: column 0 fills both A and B
                a_top <= n_top;
                a_mid <= n_mid;
                a_bot <= n_bot;
            end else begin
                a_top <= b_top;
                a_mid <= b_mid;
                a_bot <= b_bot;
            end
            b_top <= n_top;
            b_mid <= n_mid;
            b_bot <= n_bot;
        end

        // ---- stage 1: gradients ----
        gx_p1 <= gx_p0;
        gy_p1 <= gy_p0;

        // ---- stage 2: magnitude ----
        mag_p2 <= abs_g(gx_p1) + abs_g(gy_p1);
    end

endmodule

// File: tb/tb_sobel3x3_edge.sv
// -----------------------------------------------------------------------------
// tb_sobel3x3_edge
//   Drives whole frames through the three line-buffer streams and compares the
//   output stream against a replicate-border 2D Sobel computed on the frame.
// -----------------------------------------------------------------------------
module tb_sobel3x3_edge;

    localparam int DW = 8;

    logic          s_axis_aclk = 1'b0;
    logic          srst;
    logic          lb0_tvalid, lb1_tvalid, lb2_tvalid;
    logic [DW-1:0] lb0_tdata, lb1_tdata, lb2_tdata;
    logic          lb1_tlast, lb1_tuser;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic [DW-1:0] m_axis_tdata;

    always #5 s_axis_aclk = ~s_axis_aclk;

    sobel3x3_edge #(.DATA_WIDTH(DW)) dut (
        .s_axis_aclk               (s_axis_aclk),
        .srst                      (srst),
        .s_axis_line_buff_0_tvalid (lb0_tvalid),
        .s_axis_line_buff_0_tdata  (lb0_tdata),
        .s_axis_line_buff_1_tvalid (lb1_tvalid),
        .s_axis_line_buff_1_tdata  (lb1_tdata),
        .s_axis_line_buff_1_tlast  (lb1_tlast),
        .s_axis_line_buff_1_tuser  (lb1_tuser),
        .s_axis_line_buff_2_tvalid (lb2_tvalid),
        .s_axis_line_buff_2_tdata  (lb2_tdata),
        .m_axis_tvalid             (m_axis_tvalid),
        .m_axis_tdata              (m_axis_tdata),
        .m_axis_tlast              (m_axis_tlast),
        .m_axis_tuser              (m_axis_tuser)
    );

    typedef struct {
        int data;
        bit last;
        bit user;
    } exp_t;

    exp_t expq[$];
    int   tlq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   img[0:7][0:15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Sobel on the frame with replicated borders
    function automatic int sobel_px(input int h, input int w, input int y, input int x);
        int p[0:2][0:2];
        int gx, gy, mag;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = img[clampi(y + r - 1, 0, h - 1)][clampi(x + c - 1, 0, w - 1)];
        gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy  = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > 255) ? 255 : mag;
    endfunction

    always @(posedge s_axis_aclk) cyc <= cyc + 1;

    always @(negedge s_axis_aclk) begin
        exp_t e;
        int   a;
        if (m_axis_tvalid === 1'b1) begin
            if (expq.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("tdata", m_axis_tdata, e.data);
                chk("tlast", m_axis_tlast, e.last);
                chk("tuser", m_axis_tuser, e.user);
                if (e.last && tlq.size() > 0) begin
                    a = tlq.pop_front();
                    chk("tlast_latency", cyc - a, 4);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge s_axis_aclk);
            #1;
        end
    endtask

    task automatic drive_col(input int t, input bit tv, input int m, input int b,
                             input bit bv, input bit last, input bit user);
        logic [31:0] tt, mm, bb;
        tt = t; mm = m; bb = b;
        lb2_tvalid = tv;
        lb2_tdata  = tt[DW-1:0];
        lb1_tvalid = 1'b1;
        lb1_tdata  = mm[DW-1:0];
        lb1_tlast  = last;
        lb1_tuser  = user;
        lb0_tvalid = bv;
        lb0_tdata  = bb[DW-1:0];
        if (last) tlq.push_back(cyc);
        @(posedge s_axis_aclk);
        #1;
        lb0_tvalid = 1'b0;
        lb1_tvalid = 1'b0;
        lb2_tvalid = 1'b0;
        lb1_tlast  = 1'b0;
        lb1_tuser  = 1'b0;
    endtask

    task automatic drive_frame(input int h, input int w, input int gap_max);
        exp_t e;
        int   top, bot;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                e.data = sobel_px(h, w, y, x);
                e.last = (x == w - 1);
                e.user = (x == 0 && y == 0);
                expq.push_back(e);
            end
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                if (gap_max > 0) idle($urandom_range(gap_max, 0));
                // an invalid neighbour stream carries junk that must be ignored
                top = (y > 0)     ? img[y-1][x] : int'($urandom_range(255, 0));
                bot = (y < h - 1) ? img[y+1][x] : int'($urandom_range(255, 0));
                drive_col(top, y > 0, img[y][x], bot, y < h - 1, x == w - 1, x == 0 && y == 0);
            end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && expq.size() > 0; i++) @(posedge s_axis_aclk);
        #1;
        chk("drain", expq.size(), 0);
    endtask

    task automatic fill_random(input int h, input int w);
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                img[y][x] = $urandom_range(255, 0);
    endtask

    initial begin
        exp_t e;
        srst       = 1'b1;
        lb0_tvalid = 1'b0; lb0_tdata = '0;
        lb1_tvalid = 1'b0; lb1_tdata = '0; lb1_tlast = 1'b0; lb1_tuser = 1'b0;
        lb2_tvalid = 1'b0; lb2_tdata = '0;
        repeat (3) @(posedge s_axis_aclk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata",  m_axis_tdata,  0);
        chk("rst_tlast",  m_axis_tlast,  0);
        chk("rst_tuser",  m_axis_tuser,  0);
        srst = 1'b0;
        idle(1);

        // constant frame -> all zero
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) img[y][x] = 77;
        drive_frame(4, 4, 0);
        wait_drain(50);

        // vertical step edge -> 0,40,40,0 per line
        for (int y = 0; y < 4; y++) for (int x = 0; x < 4; x++) img[y][x] = (x < 2) ? 0 : 10;
        drive_frame(4, 4, 2);
        wait_drain(80);

        // horizontal step with missing top row -> 80 per pixel
        for (int x = 0; x < 4; x++) begin img[0][x] = 0; img[1][x] = 20; end
        drive_frame(2, 4, 0);
        wait_drain(50);

        // back-to-back width-3 lines
        fill_random(4, 3);
        drive_frame(4, 3, 0);
        wait_drain(50);

        // one-pixel lines
        img[0][0] = 200; img[1][0] = 200;
        drive_frame(2, 1, 0);
        wait_drain(50);

        // saturation, then reset with a pixel in flight
        for (int r = 0; r < 3; r++) begin
            img[r][0] = 0; img[r][1] = 0; img[r][2] = 255; img[r][3] = 255;
        end
        e.last = 1'b0; e.user = 1'b0;
        e.data = sobel_px(3, 4, 1, 0); expq.push_back(e);
        e.data = sobel_px(3, 4, 1, 1); expq.push_back(e);
        drive_col(0,   1, 0,   0,   1, 0, 0);
        drive_col(0,   1, 0,   0,   1, 0, 0);
        drive_col(255, 1, 255, 255, 1, 0, 0);
        wait_drain(20);
        drive_col(255, 1, 255, 255, 1, 0, 0);
        srst = 1'b1;
        @(posedge s_axis_aclk);
        #1;
        srst = 1'b0;
        chk("srst_tvalid", m_axis_tvalid, 0);
        idle(6);
        img[0][0] = 50; img[0][1] = 90;
        drive_frame(1, 2, 0);
        wait_drain(30);

        // randomized frames
        repeat (20) begin
            int h, w;
            h = $urandom_range(6, 1);
            w = $urandom_range(12, 1);
            fill_random(h, w);
            drive_frame(h, w, $urandom_range(3, 0));
        end
        wait_drain(200);
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
